// File: rtl/shift_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shift_arbiter_pkg
// Shared definitions for the two-requester shift/rotate arbiter:
//   - opcode kind encodings (top two opcode bits)
//   - opcode width computation from the operand width
//   - arbiter FSM state type
// -----------------------------------------------------------------------------
package shift_arbiter_pkg;

    // Opcode kind field, op[OW-1:OW-2]. Rotate only looks at the upper bit,
    // so 2'b10 and 2'b11 both select rotate right.
    localparam logic [1:0] KIND_SRL = 2'b00;  // logical shift right, zero fill
    localparam logic [1:0] KIND_SRA = 2'b01;  // arithmetic shift right, sign fill
    localparam logic [1:0] KIND_ROR = 2'b10;  // rotate right (2'b1x)

    function automatic bit is_rotate(input logic [1:0] kind);
        return kind[1];
    endfunction

    // Opcode = {kind[1:0], amount[AW-1:0]} with AW = clog2(width).
    function automatic int op_width(input int width);
        return $clog2(width) + 2;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,  // no result pending
        HOLD = 1'b1   // result pending on rsp_*
    } state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// -----------------------------------------------------------------------------
// shift_arbiter_if
// Bundles the two request channels and the response channel of
// shift_arbiter.
//   req0_*/req1_* : valid/ready request channels carrying operand a and opcode
//   rsp_*         : valid/ready response channel with result y and owner id
//   busy          : mirrors rsp_valid
// Modports:
//   slave  - the arbiter side (consumes requests, produces responses)
//   master - the environment side (produces requests, consumes responses)
// -----------------------------------------------------------------------------
interface shift_arbiter_if
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
);
    localparam int OW = op_width(WIDTH);

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [OW-1:0]    req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [OW-1:0]    req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_id;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_op,
        input  req1_valid, req1_a, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_y, rsp_id, busy
    );

    modport master (
        output req0_valid, req0_a, req0_op,
        output req1_valid, req1_a, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_y, rsp_id, busy
    );

endinterface

// File: rtl/shift_arbiter_rsr.sv
// -----------------------------------------------------------------------------
// rsr
// Combinational right shifter/rotator.
//   a    : operand
//   kind : KIND_SRL / KIND_SRA / KIND_ROR (2'b1x)
//   amt  : shift distance, 0..WIDTH-1
//   y    : result
// The operand is extended on the left with the fill pattern (zeros, copies of
// the sign bit, or the operand itself for rotate) and the double-width vector
// is shifted once; the low half is the result for all three kinds.
// -----------------------------------------------------------------------------
module rsr
    import shift_arbiter_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       kind,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0]   fill;
    logic [2*WIDTH-1:0] shifted;

    // NOTE: every signal written in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        fill = '0;
        if (is_rotate(kind)) begin
            fill = a;
        end else if (kind == KIND_SRA) begin
            fill = {WIDTH{a[WIDTH-1]}};
        end
        shifted = {fill, a} >> amt;
        y       = shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
// Shares one right shifter/rotator between two requesters.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : shift_arbiter_if.slave (req0_*, req1_*, rsp_*, busy)
// A request is accepted whenever the single result slot is free (idle, or the
// held result is being consumed this cycle). When both requesters are valid,
// the priority pointer picks the winner and then flips to the loser, giving
// round-robin fairness. The accepted operand/opcode are registered and the
// result is computed from those registers, so rsp_y appears one cycle after
// acceptance and stays stable under backpressure.
// The WIDTH parameter must match the WIDTH of the connected interface.
// -----------------------------------------------------------------------------
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    shift_arbiter_if.slave   bus
);

    localparam int AW = $clog2(WIDTH);
    localparam int OW = op_width(WIDTH);

    state_t           state, state_nxt;
    logic             ptr;
    logic [WIDTH-1:0] a_q;
    logic [OW-1:0]    op_q;
    logic             id_q;

    logic             slot_free;
    logic             grant;
    logic             winner;

    // Arbitration and next state. Reset gates the grant so no requester sees
    // ready while the block is being cleared.
    always_comb begin
        state_nxt = state;
        slot_free = (state == IDLE) || bus.rsp_ready;
        winner    = (bus.req0_valid && bus.req1_valid) ? ptr : bus.req1_valid;
        grant     = slot_free && (bus.req0_valid || bus.req1_valid) && !rst;

        if (slot_free) begin
            state_nxt = grant ? HOLD : IDLE;
        end
    end

    assign bus.req0_ready = grant && !winner;
    assign bus.req1_ready = grant &&  winner;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand/opcode registers are reset as well because
            // rsp_y is decoded from them and must read zero after reset.
            state <= IDLE;
            ptr   <= 1'b0;
            a_q   <= '0;
            op_q  <= '0;
            id_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                a_q  <= winner ? bus.req1_a  : bus.req0_a;
                op_q <= winner ? bus.req1_op : bus.req0_op;
                id_q <= winner;
                ptr  <= ~winner;
            end
        end
    end

    rsr #(
        .WIDTH (WIDTH)
    ) u_rsr (
        .a    (a_q),
        .kind (op_q[OW-1:OW-2]),
        .amt  (op_q[AW-1:0]),
        .y    (bus.rsp_y)
    );

    assign bus.rsp_valid = (state == HOLD);
    assign bus.busy      = (state == HOLD);
    assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
// Self-checking bench for shift_arbiter at WIDTH=8 (OW=5). A reference model
// tracks the pending result, its owner and the priority pointer using the
// block's rules directly; the shift result is computed with plain integer
// arithmetic.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

    localparam int WIDTH = 8;
    localparam int OW    = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_arbiter_if #(.WIDTH(WIDTH)) bus ();

    shift_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit         m_pend;
    bit         m_id;
    bit         m_ptr;
    logic [7:0] m_y;

    // Reference shift: integer arithmetic on the 8-bit operand.
    function automatic logic [7:0] ref_shift(input logic [7:0] a, input logic [4:0] op);
        int amt;
        int v;
        amt = int'(op[2:0]);
        if (op[4]) begin
            v = (int'(a) * 257) >> amt;          // {a,a} shifted: rotate
        end else if (op[3]) begin
            v = (int'(a) >= 128) ? int'(a) - 256 : int'(a);
            v = v >>> amt;                       // sign-preserving divide
        end else begin
            v = int'(a) >> amt;
        end
        return v[7:0];
    endfunction

    // One clock cycle: drive inputs at the falling edge, check the
    // combinational grants, advance the model at the rising edge, then check
    // the response outputs at the next falling edge.
    task automatic step(input logic v0, input logic v1,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [4:0] op0, input logic [4:0] op1,
                        input logic rr,
                        output logic g0, output logic g1);
        bit free;
        bit any;
        bit win;
        bit e0;
        bit e1;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_a     = a0;
        bus.req1_a     = a1;
        bus.req0_op    = op0;
        bus.req1_op    = op1;
        bus.rsp_ready  = rr;
        #1;
        free = !m_pend || rr;
        any  = free && (v0 || v1);
        win  = (v0 && v1) ? m_ptr : v1;
        e0   = any && !win;
        e1   = any && win;
        g0   = bus.req0_ready;
        g1   = bus.req1_ready;
        n_checks++;
        if (g0 !== e0 || g1 !== e1) begin
            n_fail++;
            $display("FAIL ready_grant: got r0=%b r1=%b expected r0=%b r1=%b (t=%0t)",
                     g0, g1, e0, e1, $time);
        end
        @(posedge clk);
        if (free) begin
            if (any) begin
                m_pend = 1'b1;
                m_id   = win;
                m_y    = ref_shift(win ? a1 : a0, win ? op1 : op0);
                m_ptr  = !win;
            end else begin
                m_pend = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== m_pend || bus.busy !== m_pend) begin
            n_fail++;
            $display("FAIL rsp_valid_busy: got valid=%b busy=%b expected %b (t=%0t)",
                     bus.rsp_valid, bus.busy, m_pend, $time);
        end
        if (m_pend) begin
            n_checks++;
            if (bus.rsp_y !== m_y || bus.rsp_id !== m_id) begin
                n_fail++;
                $display("FAIL rsp_data: got y=%h id=%b expected y=%h id=%b (t=%0t)",
                         bus.rsp_y, bus.rsp_id, m_y, m_id, $time);
            end
        end
    endtask

    task automatic idle_cycle();
        logic g0, g1;
        step(1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 5'd0, 1'b1, g0, g1);
    endtask

    // Reset with the given valids asserted; ready must stay low throughout.
    task automatic do_reset(input logic v0, input logic v1);
        rst            = 1'b1;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_a     = 8'hA5;
        bus.req1_a     = 8'h5A;
        bus.req0_op    = 5'b01_001;
        bus.req1_op    = 5'b10_001;
        bus.rsp_ready  = 1'b1;
        #1;
        n_checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_reset: got r0=%b r1=%b expected 0 0",
                     bus.req0_ready, bus.req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_pend = 1'b0;
        m_ptr  = 1'b0;
        m_id   = 1'b0;
        m_y    = 8'h00;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.rsp_y !== 8'h00 || bus.rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b busy=%b y=%h id=%b expected 0 0 00 0",
                     bus.rsp_valid, bus.busy, bus.rsp_y, bus.rsp_id);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
    endtask

    task automatic test_sra();
        logic g0, g1;
        step(1'b1, 1'b0, 8'h96, 8'h00, 5'b01_010, 5'd0, 1'b1, g0, g1);
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 8'hE5 || bus.rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL sra_directed: got valid=%b y=%h id=%b expected 1 e5 0",
                     bus.rsp_valid, bus.rsp_y, bus.rsp_id);
        end
        idle_cycle();
    endtask

    task automatic test_req1_sequence();
        logic [4:0] ops [3];
        logic [7:0] exp [3];
        logic g0, g1;
        ops = '{5'b00_010, 5'b10_011, 5'b00_000};
        exp = '{8'h25, 8'hD2, 8'h96};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00, 8'h96, 5'd0, ops[i], 1'b1, g0, g1);
            n_checks++;
            if (bus.rsp_y !== exp[i] || bus.rsp_id !== 1'b1) begin
                n_fail++;
                $display("FAIL req1_seq_%0d: got y=%h id=%b expected y=%h id=1",
                         i, bus.rsp_y, bus.rsp_id, exp[i]);
            end
        end
        idle_cycle();
    endtask

    task automatic test_alternation();
        logic g0, g1;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, g0, g1);
            n_checks++;
            if (g0 !== ((i % 2) == 0) || g1 !== ((i % 2) == 1) ||
                bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'((i % 2))) begin
                n_fail++;
                $display("FAIL alternation_%0d: got r0=%b r1=%b valid=%b id=%b expected winner %0d",
                         i, g0, g1, bus.rsp_valid, bus.rsp_id, i % 2);
            end
        end
        idle_cycle();
    endtask

    task automatic test_backpressure();
        logic g0, g1;
        logic [7:0] y_hold;
        logic       id_hold;
        step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'h00,
             5'($urandom_range(0, 31)), 5'd0, 1'b1, g0, g1);
        y_hold  = bus.rsp_y;
        id_hold = bus.rsp_id;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0, g0, g1);
            n_checks++;
            if (g0 !== 1'b0 || g1 !== 1'b0 || bus.rsp_valid !== 1'b1 ||
                bus.rsp_y !== y_hold || bus.rsp_id !== id_hold) begin
                n_fail++;
                $display("FAIL backpressure_%0d: got r0=%b r1=%b valid=%b y=%h id=%b expected 0 0 1 %h %b",
                         i, g0, g1, bus.rsp_valid, bus.rsp_y, bus.rsp_id, y_hold, id_hold);
            end
        end
        idle_cycle();
    endtask

    task automatic test_reset_in_hold();
        logic g0, g1;
        // Move the pointer to requester 0 first, then leave a result pending.
        step(1'b0, 1'b1, 8'h00, 8'h3C, 5'd0, 5'b00_001, 1'b1, g0, g1);
        do_reset(1'b1, 1'b1);
        step(1'b1, 1'b1, 8'h81, 8'h42, 5'b10_001, 5'b00_001, 1'b1, g0, g1);
        n_checks++;
        if (g0 !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_y !== 8'hC0) begin
            n_fail++;
            $display("FAIL reset_in_hold_grant: got r0=%b id=%b y=%h expected 1 0 c0",
                     g0, bus.rsp_id, bus.rsp_y);
        end
        idle_cycle();
    endtask

    task automatic test_random();
        logic g0, g1;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 3) != 0), g0, g1);
        end
        idle_cycle();
    endtask

    initial begin
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req1_a     = '0;
        bus.req0_op    = '0;
        bus.req1_op    = '0;
        bus.rsp_ready  = 1'b0;
        m_pend = 1'b0;
        m_ptr  = 1'b0;
        m_id   = 1'b0;
        m_y    = 8'h00;
        @(negedge clk);

        test_reset();
        test_sra();
        test_req1_sequence();
        test_alternation();
        test_backpressure();
        test_reset_in_hold();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits; power of two, >= 4.
REQ-002 Localparam AW = $clog2(WIDTH), the shift-amount width; localparam OW = AW+2, the opcode width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req0_valid  input  1  requester 0 presents a shift request.
REQ-006 req0_ready  output  1  requester 0 request accepted this cycle.
REQ-007 req0_a  input  WIDTH  requester 0 operand.
REQ-008 req0_op  input  OW  requester 0 opcode; {op[OW-1:OW-2], amount[AW-1:0]}.
REQ-009 req1_valid, req1_ready, req1_a, req1_op: same as REQ-005..REQ-008, for requester 1.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 rsp_y  output  WIDTH  shift/rotate result.
REQ-013 rsp_id  output  1  index of the requester that owns rsp_y.
REQ-014 busy  output  1  equals rsp_valid.

Function
REQ-015 The block shall share one right shifter/rotator between the two requesters.
REQ-016 Opcode kind field op[OW-1:OW-2]:
- 00: logical shift right, zero fill
- 01: arithmetic shift right, sign fill
- 1x: rotate right
Shift distance shall be amount (0..WIDTH-1).
REQ-017 FSM states:
- IDLE: no result pending.
- HOLD: result pending on rsp_*.
REQ-018 Slot free condition: state==IDLE, or (state==HOLD and rsp_ready==1).
REQ-019 Grant, slot free:
- only reqK_valid high: requester K wins.
- both valid: the requester named by priority pointer ptr wins.
REQ-020 reqK_ready shall be high only for the winner, only in a slot-free cycle, combinationally from current valids, ptr and state.
REQ-021 On acceptance, operand, opcode and winner index shall be registered, state -> HOLD, and ptr <= 1 - winner.
REQ-022 Latency: rsp_valid shall rise the cycle after acceptance; rsp_y = shift of the registered operand, combinational from registers only.
REQ-023 In HOLD with rsp_ready low: rsp_y and rsp_id shall hold stable; both reqK_ready shall be low.
REQ-024 In HOLD with rsp_ready high and a winner present: the new request shall be accepted the same cycle; state stays HOLD (throughput one per cycle).
REQ-025 In HOLD with rsp_ready high and no valid requester: state -> IDLE, rsp_valid low next cycle.
REQ-026 ptr shall not change in cycles without an acceptance.
REQ-027 A requester that drops valid before being granted shall not be recorded.

Reset
REQ-028 On rst high at a rising edge, the block shall reset:
- state=IDLE, ptr=0
- rsp_valid=0, rsp_id=0, busy=0
- registered operand=0, opcode=0, so rsp_y=0
REQ-029 While rst is high, req0_ready and req1_ready shall be low.
REQ-030 Reset in HOLD shall discard the pending result without handshake.

Structure
REQ-031 Opcode kind encodings (SRL=2'b00, SRA=2'b01, ROR=2'b1x) shall be constants in a shared package, together with the OW computation.
REQ-032 The shifter shall be one instance of the existing combinational rsr sub-module (width=WIDTH), fed by the registered operand and opcode.
REQ-033 Arbitration, FSM and registers shall be in shift_arbiter itself.

Verification
REQ-034 Test parameter: WIDTH=8, OW=5.
REQ-035 req0 a=0x96 op=5'b01_010 (SRA 2) -> rsp_valid next cycle, rsp_y=0xE5, rsp_id=0.
REQ-036 req1 a=0x96, three requests in sequence -> rsp_id=1 each time:
- op=5'b00_010 (SRL 2) -> rsp_y=0x25
- op=5'b10_011 (ROR 3) -> rsp_y=0xD2
- op=5'b00_000 -> rsp_y=0x96
REQ-037 After reset, both valid continuously, rsp_ready=1 -> grants 0,1,0,1 on consecutive cycles; rsp_valid stays high.
REQ-038 Backpressure: accept a request, hold rsp_ready=0 for 3 cycles -> rsp_y/rsp_id stable; req0_ready=req1_ready=0 throughout.
REQ-039 rst asserted while in HOLD -> next cycle rsp_valid=0, rsp_y=0, ptr=0; a simultaneous req0/req1 afterwards grants req0.
